axis_rr_packet_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one downstream AXI4-Stream port between C_NUM_SI upstream AXI4-Stream masters. It sits in the platform stream infrastructure in front of a single shared sink, such as a kernel stream input or a wirethrough to a platform stream port. Grant is held from the first beat to the TLAST beat, so packets from different sources are never interleaved. TDATA, TKEEP, TLAST and TUSER pass combinationally from the granted source; only the grant and state are registered.

---
 rtl/axis_rr_packet_arbiter.sv | 110 +++++++++++
 tb/tb_axis_rr_packet_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter merging C_NUM_SI AXI4-Stream sources onto one sink.
// Optional source tagging on m_tid is enabled by defining AXIS_RR_ARB_TID_EN.
module axis_rr_packet_arbiter #(
    parameter int C_NUM_SI      = 4,
    parameter int C_TDATA_WIDTH = 64,
    parameter int C_TUSER_WIDTH = 1,
    parameter int C_TID_WIDTH   = 3,
    localparam int GW           = $clog2(C_NUM_SI),
    localparam int KW           = C_TDATA_WIDTH / 8
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [C_NUM_SI-1:0]                s_tvalid,
    output logic [C_NUM_SI-1:0]                s_tready,
    input  logic [C_NUM_SI*C_TDATA_WIDTH-1:0]  s_tdata,
    input  logic [C_NUM_SI*KW-1:0]             s_tkeep,
    input  logic [C_NUM_SI-1:0]                s_tlast,
    input  logic [C_NUM_SI*C_TUSER_WIDTH-1:0]  s_tuser,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic [C_TDATA_WIDTH-1:0]           m_tdata,
    output logic [KW-1:0]                      m_tkeep,
    output logic                               m_tlast,
    output logic [C_TUSER_WIDTH-1:0]           m_tuser,
    output logic [C_TID_WIDTH-1:0]             m_tid,
    output logic [GW-1:0]                      grant_idx,
    output logic                               busy,
    output logic [15:0]                        pkt_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]    state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] winner;
    logic          found;
    int            cand;
    logic          pkt_done;

    assign busy     = (state == XFER);
    assign pkt_done = busy & m_tvalid & m_tready & m_tlast;

    // Scan upward from the source after the last grant; the first requester wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 1; k <= C_NUM_SI; k++) begin
            cand = (int'(last_grant) + k) % C_NUM_SI;
            if (!found && s_tvalid[cand]) begin
                winner = GW'(cand);
                found  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            last_grant <= GW'(C_NUM_SI - 1);
            grant_idx  <= '0;
            pkt_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_tvalid) begin
                        state     <= XFER;
                        grant_idx <= winner;
                    end
                end
                XFER: begin
                    if (pkt_done) begin
                        state      <= IDLE;
                        last_grant <= grant_idx;
                        pkt_cnt    <= pkt_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload is forced to zero outside XFER so reset and idle never expose source data.
    always_comb begin
        m_tvalid = 1'b0;
        s_tready = '0;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tlast  = 1'b0;
        m_tuser  = '0;
        if (busy) begin
            m_tvalid            = s_tvalid[grant_idx];
            s_tready[grant_idx] = m_tready;
            m_tdata             = s_tdata[int'(grant_idx)*C_TDATA_WIDTH +: C_TDATA_WIDTH];
            m_tkeep             = s_tkeep[int'(grant_idx)*KW +: KW];
            m_tlast             = s_tlast[grant_idx];
            m_tuser             = s_tuser[int'(grant_idx)*C_TUSER_WIDTH +: C_TUSER_WIDTH];
        end
    end

`ifdef AXIS_RR_ARB_TID_EN
    assign m_tid = C_TID_WIDTH'(grant_idx);
`else
    assign m_tid = '0;
`endif

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Randomized and directed bench for axis_rr_packet_arbiter against a transaction-level
// arbiter model (owner / last winner / packet count) kept in the bench.
module tb_axis_rr_packet_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int U  = 1;
    localparam int T  = 3;
    localparam int GW = 2;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [N-1:0]     s_tvalid = '0;
    logic [N-1:0]     s_tready;
    logic [N*W-1:0]   s_tdata = '0;
    logic [N*W/8-1:0] s_tkeep = '0;
    logic [N-1:0]     s_tlast = '0;
    logic [N*U-1:0]   s_tuser = '0;
    logic             m_tvalid;
    logic             m_tready = 1'b1;
    logic [W-1:0]     m_tdata;
    logic [W/8-1:0]   m_tkeep;
    logic             m_tlast;
    logic [U-1:0]     m_tuser;
    logic [T-1:0]     m_tid;
    logic [GW-1:0]    grant_idx;
    logic             busy;
    logic [15:0]      pkt_cnt;

    axis_rr_packet_arbiter #(
        .C_NUM_SI(N), .C_TDATA_WIDTH(W), .C_TUSER_WIDTH(U), .C_TID_WIDTH(T)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tid(m_tid),
        .grant_idx(grant_idx), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Source stimulus state
    int   plen[N], pos[N], seq[N], left[N];
    logic v[N];
    logic [N-1:0] en = '0;
    int   pct = 100, fixed_len = 0, ready_mode = 0;
    int   stall_src = -1, stall_pos = 1, stall_left = 0;

    // Reference model state
    int   owner, last_g, gidx, cnt;
    int   cyc = 0;

    // Observation
    int   grants[$];
    int   beats, first_req_cyc, first_v_cyc;
    logic [7:0] first_lo;
    logic prev_busy;

    function automatic logic [63:0] beat_data(int i);
        return {8'(i), 8'(seq[i]), 40'h0, 8'(8'hA0 + pos[i])};
    endfunction

    function automatic int new_len();
        return (fixed_len > 0) ? fixed_len : int'($urandom_range(4, 1));
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i] = v[i];
            if (v[i]) begin
                s_tdata[i*W +: W] = beat_data(i);
                s_tkeep[i*8 +: 8] = 8'(seq[i]*3 + pos[i]);
                s_tlast[i]        = (pos[i] == plen[i] - 1);
                s_tuser[i]        = 1'(pos[i]);
            end else begin
                s_tdata[i*W +: W] = {$urandom, $urandom};
                s_tkeep[i*8 +: 8] = 8'($urandom);
                s_tlast[i]        = 1'($urandom);
                s_tuser[i]        = 1'($urandom);
            end
        end
    endtask

    task automatic decide(input logic [N-1:0] hs);
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if (pos[i] == plen[i] - 1) begin
                    pos[i] = 0;
                    seq[i]++;
                    if (left[i] > 0) left[i]--;
                    plen[i] = new_len();
                end else begin
                    pos[i]++;
                end
                v[i] = 1'b0;
            end
            if (!v[i]) begin
                if (i == stall_src && pos[i] == stall_pos && stall_left > 0)
                    stall_left--;
                else
                    v[i] = en[i] && (left[i] != 0) && ($urandom_range(99) < pct);
                if (v[i] && first_req_cyc < 0) first_req_cyc = cyc;
            end
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            pos[i] = 0; seq[i] = 0; v[i] = 1'b0; plen[i] = new_len();
        end
        owner = -1; last_g = N - 1; gidx = 0; cnt = 0;
        grants.delete();
        beats = 0; first_req_cyc = -1; first_v_cyc = -1; first_lo = '0;
        prev_busy = 1'b0;
        m_tready = 1'b1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_m_tvalid"}, m_tvalid, 0);
        check({tag, "_s_tready"}, s_tready, 0);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_m_tdata"},  m_tdata, 0);
        check({tag, "_m_tlast"},  m_tlast, 0);
        check({tag, "_m_tid"},    m_tid, 0);
    endtask

    // Asserts reset asynchronously from wherever we are, checks outputs, then restarts sources.
    task automatic do_reset(input string tag);
        aresetn = 1'b0;
        #1;
        reset_checks(tag);
        clear_all();
        drive_inputs();
        repeat (2) @(posedge aclk);
        #1;
        check({tag, "_grant_idx"}, grant_idx, 0);
        check({tag, "_pkt_cnt"},   pkt_cnt, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        decide('0);
        drive_inputs();
    endtask

    // One clock: compare at negedge, advance model at posedge, re-drive sources after it.
    task automatic cycle();
        logic         exp_v, exp_last, done;
        logic [N-1:0] exp_rdy, hs;
        logic [63:0]  exp_d;
        logic [7:0]   exp_k;
        logic         exp_u;
        @(negedge aclk);
        exp_v = 1'b0; exp_last = 1'b0; exp_rdy = '0; exp_d = '0; exp_k = '0; exp_u = 1'b0;
        if (owner >= 0) begin
            exp_v          = s_tvalid[owner];
            exp_rdy[owner] = m_tready;
            exp_d          = s_tdata[owner*W +: W];
            exp_k          = s_tkeep[owner*8 +: 8];
            exp_last       = s_tlast[owner];
            exp_u          = s_tuser[owner];
        end
        check("m_tvalid",  m_tvalid, exp_v);
        check("s_tready",  s_tready, exp_rdy);
        check("busy",      busy, owner >= 0);
        check("m_tdata",   m_tdata, exp_d);
        check("m_tkeep",   m_tkeep, exp_k);
        check("m_tlast",   m_tlast, exp_last);
        check("m_tuser",   m_tuser, exp_u);
        check("grant_idx", grant_idx, gidx);
        check("pkt_cnt",   pkt_cnt, cnt);
`ifdef AXIS_RR_ARB_TID_EN
        if (exp_v) check("m_tid", m_tid, owner);
`else
        check("m_tid", m_tid, 0);
`endif
        if (busy && !prev_busy) grants.push_back(int'(grant_idx));
        prev_busy = busy;
        if (m_tvalid && m_tready) beats++;
        if (m_tvalid && first_v_cyc < 0) begin
            first_v_cyc = cyc;
            first_lo    = m_tdata[7:0];
        end
        hs   = s_tvalid & exp_rdy;
        done = exp_v & m_tready & exp_last;
        @(posedge aclk);
        if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (owner < 0 && s_tvalid[(last_g + k) % N]) owner = (last_g + k) % N;
            end
            if (owner >= 0) gidx = owner;
        end else if (done) begin
            last_g = owner;
            owner  = -1;
            cnt    = (cnt + 1) % 65536;
        end
        cyc++;
        #1;
        case (ready_mode)
            1:       m_tready = ~m_tready;
            2:       m_tready = ($urandom_range(99) < 70);
            default: m_tready = 1'b1;
        endcase
        decide(hs);
        drive_inputs();
    endtask

    task automatic run_until_cnt(input string tag, input int target, input int budget);
        int n = 0;
        while (cnt < target && n < budget) begin
            cycle();
            n++;
        end
        if (cnt < target) check({tag, "_timeout"}, pkt_cnt, target);
    endtask

    task automatic setup(input logic [N-1:0] mask, input int p, input int len, input int pkts,
                         input int rmode);
        en = mask; pct = p; fixed_len = len; ready_mode = rmode;
        for (int i = 0; i < N; i++) left[i] = pkts;
        stall_src = -1; stall_left = 0;
    endtask

    initial begin
        int n;
        // Single source 2, 4-beat packet
        setup(4'b0100, 100, 4, 1, 0);
        do_reset("rst0");
        run_until_cnt("single", 1, 50);
        repeat (2) cycle();
        check("single_beats",   beats, 4);
        check("single_latency", first_v_cyc - first_req_cyc, 1);
        check("single_first",   first_lo, 8'hA0);
        check("single_grant",   grant_idx, 2);
        check("single_cnt",     pkt_cnt, 1);

        // Round-robin, all sources offering 2-beat packets
        setup(4'b1111, 100, 2, 2, 0);
        do_reset("rst1");
        run_until_cnt("rr", 8, 200);
        for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), grants[i], i % N);
        check("rr_beats", beats, 16);

        // Backpressure, toggling ready during a 3-beat packet from source 1
        setup(4'b0010, 100, 3, 1, 1);
        do_reset("rst2");
        run_until_cnt("bp", 1, 50);
        repeat (3) cycle();
        check("bp_beats", beats, 3);

        // Source 0 stalls for 5 cycles after beat 1 while source 3 waits
        setup(4'b1001, 100, 4, 1, 0);
        stall_src = 0; stall_pos = 1; stall_left = 5;
        do_reset("rst3");
        run_until_cnt("stall", 2, 100);
        check("stall_first",  grants[0], 0);
        check("stall_second", grants[1], 3);

        // Reset after beat 2 of a 4-beat packet
        setup(4'b0001, 100, 4, 1, 0);
        do_reset("rst4");
        n = 0;
        while (beats < 2 && n < 50) begin
            cycle();
            n++;
        end
        check("midrst_beats", beats, 2);
        #2;
        do_reset("midrst");
        setup(4'b0101, 100, 3, 1, 0);
        decide('0);
        drive_inputs();
        run_until_cnt("post_rst", 2, 100);
        check("post_rst_first", grants[0], 0);

        // Random traffic with random backpressure
        setup(4'b1111, 60, 0, -1, 2);
        do_reset("rst5");
        repeat (1500) cycle();
        for (int i = 0; i < N; i++) left[i] = (v[i] || pos[i] != 0) ? 1 : 0;
        ready_mode = 0;
        n = 0;
        while ((owner >= 0 || (|s_tvalid)) && n < 500) begin
            cycle();
            n++;
        end
        check("drain_idle", busy, 0);
        check("rand_cnt", pkt_cnt, cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
